// File: rtl/uart_tx_fifo_if.sv
// Byte handshake bundle between an upstream producer, the FIFO and uart_tx.
// The i_* signals face the producer and the o_* signals face uart_tx, both seen from the FIFO side.
interface uart_tx_fifo_if;
    logic       i_wreq;
    logic       i_wgnt;
    logic [7:0] i_wdata;
    logic       o_wreq;
    logic       o_wgnt;
    logic [7:0] o_wdata;

    modport slave (
        input  i_wreq, i_wdata, o_wgnt,
        output i_wgnt, o_wreq, o_wdata
    );

    modport master (
        output i_wreq, i_wdata, o_wgnt,
        input  i_wgnt, o_wreq, o_wdata
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that feeds uart_tx.
// Bytes offered while the FIFO is full are dropped and counted in a saturating counter.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_fifo_if.slave         bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2:0]   r_wp;
    logic [DEPTH_LOG2:0]   r_rp;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_cnt;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_drop;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    // The extra pointer MSB tells full apart from empty when the low bits match.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[DEPTH_LOG2-1:0] == r_rp[DEPTH_LOG2-1:0]) &&
                     (r_wp[DEPTH_LOG2] != r_rp[DEPTH_LOG2]);

    assign bus.i_wgnt  = !w_full && !rst;
    assign bus.o_wreq  = !w_empty && !rst;
    assign bus.o_wdata = r_mem[r_rp[DEPTH_LOG2-1:0]];

    assign w_wr   = bus.i_wreq && bus.i_wgnt;
    assign w_rd   = bus.o_wreq && bus.o_wgnt;
    assign w_drop = bus.i_wreq && w_full && !rst;

    assign level    = r_wp - r_rp;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr)   r_wp <= r_wp + (DEPTH_LOG2+1)'(1);
            if (w_rd)   r_rp <= r_rp + (DEPTH_LOG2+1)'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    // Storage is left uncleared by reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[DEPTH_LOG2-1:0]] <= bus.i_wdata;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO placed directly upstream of uart_tx. It decouples bursty byte producers (button/switch samplers, counters, debug taps) from the UART line rate.
- Upstream side uses a wreq/wgnt handshake. Downstream side drives uart_tx's wreq/wgnt/wdata ports directly.
- Bytes offered while the FIFO is full are dropped and counted, so producers never stall the design.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (default 16). Legal range 1..10.
- DROP_W, 16: width of the saturating dropped-byte counter.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_wreq  input  1  upstream byte-valid request
- i_wgnt  output  1  upstream grant; high when FIFO can accept a byte
- i_wdata  input  8  upstream byte
- o_wreq  output  1  request to uart_tx; high when FIFO is non-empty
- o_wgnt  input  1  grant from uart_tx
- o_wdata  output  8  byte at FIFO head (first-word-fall-through)
- level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
- overflow  output  1  sticky; set on first dropped byte
- drop_cnt  output  DROP_W  count of dropped bytes, saturating

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high; polarity and synchronicity are fixed.
- Storage:
  - 2^DEPTH_LOG2 x 8 register array.
  - Write pointer wp and read pointer rp, each DEPTH_LOG2+1 bits.
  - Array is indexed by the low DEPTH_LOG2 bits. Pointers wrap naturally modulo 2^(DEPTH_LOG2+1).
- Status:
  - empty = (wp == rp).
  - full = (low bits equal) AND (MSBs differ).
  - level = wp - rp, computed modulo 2^(DEPTH_LOG2+1).
- Reset (rst=1 at a clock edge):
  - wp=rp=0, level=0, overflow=0, drop_cnt=0.
  - Array contents are don't-care and are not cleared.
  - While rst is high, i_wgnt=0 and o_wreq=0.
  - Reset mid-operation discards all stored bytes. There is no partial-byte hazard: uart_tx owns its shift register.
- Write handshake:
  - i_wgnt = !full && !rst. Purely a function of registered state; no combinational path from o_wgnt.
  - A write occurs when i_wreq && i_wgnt at a rising edge: mem[wp] <= i_wdata, wp <= wp+1.
  - Full and a read in the same cycle: the write is still refused (no same-cycle pass-through).
- Drop:
  - i_wreq && full && !rst at an edge sets overflow <= 1.
  - Same condition increments drop_cnt, saturating at 2^DROP_W-1.
  - The byte is discarded.
  - overflow clears only on rst.
- Read handshake:
  - o_wreq = !empty && !rst. o_wdata = mem[rp], combinational from the array.
  - o_wdata is don't-care when o_wreq=0.
  - A read occurs when o_wreq && o_wgnt at an edge: rp <= rp+1.
  - o_wdata must stay stable while o_wreq=1 and o_wgnt=0.
- Latency:
  - A byte written into an empty FIFO at edge N appears on o_wreq/o_wdata after edge N (visible in cycle N+1). No earlier bypass.
  - Minimum write-to-read turnaround is 1 cycle.
- Simultaneous read and write (neither empty nor full): both pointers advance and level is unchanged.
- Empty plus a write: no read occurs that cycle, since o_wreq=0.
- Ordering: strict FIFO; bytes leave in acceptance order. No byte is duplicated or lost except as counted in drop_cnt.
- No X on any output after the first edge with rst=1.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 3 cycles with i_wreq=1, i_wdata=8'hAA.
  - Required: i_wgnt=0, o_wreq=0, level=0, drop_cnt=0, overflow=0.
  - After release, i_wgnt=1 in the first cycle.
- Single byte:
  - Stimulus: o_wgnt=0; write 8'h5A at edge N.
  - Required: o_wreq=1 and o_wdata=8'h5A from cycle N+1; level=1.
  - Then o_wgnt=1 for one edge: o_wreq=0, level=0.
- Fill and overflow (default DEPTH_LOG2=4, o_wgnt=0):
  - Stimulus: write 16 bytes 8'h00..8'h0F, then offer 3 more bytes 8'hE0..8'hE2.
  - Required: level=16, i_wgnt=0, drop_cnt=3, overflow=1.
  - Draining yields exactly 8'h00..8'h0F, then o_wreq=0.
- Concurrent streaming:
  - Stimulus: preload 4 bytes, then for 40 cycles i_wreq=1 with an incrementing byte and o_wgnt=1.
  - Required: level stays 4 throughout; output sequence is the input sequence delayed by 4 entries; pointer wrap crossed twice with no corruption.
- Backpressure stability:
  - Stimulus: with o_wreq=1 and head byte 8'h3C, toggle o_wgnt as 0,0,0,1.
  - Required: o_wdata=8'h3C for all 3 stalled cycles; exactly one byte consumed.
- Reset mid-operation and drop saturation:
  - Reset with level=9: the cycle after rst release shows level=0, o_wreq=0, and the next write is the next byte out.
  - Separate run with DROP_W=2, full FIFO, 6 offers: drop_cnt ends at 3.
